// File: rtl/sha3_perm_sched.sv
// Two-client scheduler for the shared SHA3-512 f_permutation: one message per grant.
// Define SHA3_SCHED_FIXED_PRIO_EN to replace round-robin tie-breaking with fixed client-0 priority.
`timescale 1ns/1ps
module sha3_perm_sched #(
    parameter int DIGEST_W = 512,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [575:0]        req_block0,
    input  logic [575:0]        req_block1,
    input  logic [1:0]          req_last,
    output logic [1:0]          req_ack,
    output logic                perm_reset,
    output logic [575:0]        perm_in,
    output logic                perm_in_ready,
    input  logic                perm_ack,
    input  logic [1599:0]       perm_out,
    input  logic                perm_out_ready,
    output logic                dig_valid,
    output logic                dig_id,
    output logic [DIGEST_W-1:0] digest,
    input  logic                dig_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    blk_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] state;
    logic       grant;
    logic       last_r;
    logic       pick;
    logic       accept;
    logic       unused_perm_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef SHA3_SCHED_FIXED_PRIO_EN
    assign pick = ~req_valid[0];
`else
    logic rr_ptr;
    // Ties go to rr_ptr; a lone requester wins outright.
    assign pick = (&req_valid) ? rr_ptr : req_valid[1];
`endif

    assign perm_in       = grant ? req_block1 : req_block0;
    assign perm_in_ready = !reset && (state == S_FEED) && req_valid[grant];
    assign accept        = perm_in_ready && perm_ack;
    assign req_ack       = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign perm_reset    = reset || (state == S_CLEAR);
    assign busy          = (state != S_IDLE);

    // Only the digest slice of the permutation state is consumed.
    assign unused_perm_bits = ^perm_out[1599-DIGEST_W:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            grant     <= 1'b0;
            last_r    <= 1'b0;
            dig_valid <= 1'b0;
            dig_id    <= 1'b0;
            digest    <= '0;
            blk_cnt   <= '0;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    blk_cnt <= '0;
                    state   <= S_FEED;
                end
                S_FEED: begin
                    if (accept) begin
                        blk_cnt <= sat_inc(blk_cnt);
                        last_r  <= req_last[grant];
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (perm_out_ready) begin
                        if (last_r) begin
                            digest    <= perm_out[1599 -: DIGEST_W];
                            dig_valid <= 1'b1;
                            dig_id    <= grant;
                            state     <= S_DONE;
                        end else begin
                            state <= S_FEED;
                        end
                    end
                end
                S_DONE: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
                        rr_ptr    <= ~grant;
`endif
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
